// File: rtl/params_pkg.sv
// Shared types and constants for the multiply execute pipeline.
package params_pkg;

  localparam int REGISTER_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_STAGES     = 5;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHU  = 2'd2,
    MULHSU = 2'd3
  } ex_op_t;

  typedef struct packed {
    logic                      valid;
    ex_op_t                    op;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     data;
  } ex_stage_t;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic rs1_is_signed(ex_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic rs2_is_signed(ex_op_t op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/ex_mul_datapath.sv
// Multiplier datapath for ex1..ex4: operand capture with sign extension,
// four half-width partial products, their sum into the full product,
// and the per-op half select. All stages share one enable.
module ex_mul_datapath
  import params_pkg::*;
#(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  ex_op_t                issue_op_i,
  input  logic [DATA_WIDTH-1:0] issue_rs1_val_i,
  input  logic [DATA_WIDTH-1:0] issue_rs2_val_i,
  input  ex_op_t                ex3_op_i,
  output logic [DATA_WIDTH-1:0] ex4_result_o
);

  // Operands are DATA_WIDTH+1 bits once sign/zero extended; the upper piece
  // is HALF+1 bits signed, the lower piece HALF bits unsigned.
  localparam int HALF = DATA_WIDTH / 2;
  localparam int XW   = DATA_WIDTH + 1;
  localparam int PW   = 2 * HALF + 2;
  localparam int PRW  = 2 * DATA_WIDTH;

  logic [XW-1:0]         a_q, b_q;
  logic [PW-1:0]         a_lo_x, a_hi_x, b_lo_x, b_hi_x;
  logic [PW-1:0]         pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic [PRW-1:0]        ll_x, lh_x, hl_x, hh_x;
  logic [PRW-1:0]        product_d, product_q;
  logic [DATA_WIDTH-1:0] result_q;

  // ex1: capture operands, extending each by one bit according to the op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
    end else if (en_i) begin
      a_q <= {rs1_is_signed(issue_op_i) & issue_rs1_val_i[DATA_WIDTH-1], issue_rs1_val_i};
      b_q <= {rs2_is_signed(issue_op_i) & issue_rs2_val_i[DATA_WIDTH-1], issue_rs2_val_i};
    end
  end

  // Split each operand and widen the pieces so products are exact in PW bits.
  always_comb begin
    a_lo_x = {{(PW-HALF){1'b0}}, a_q[HALF-1:0]};
    a_hi_x = {{(PW-HALF-1){a_q[XW-1]}}, a_q[XW-1:HALF]};
    b_lo_x = {{(PW-HALF){1'b0}}, b_q[HALF-1:0]};
    b_hi_x = {{(PW-HALF-1){b_q[XW-1]}}, b_q[XW-1:HALF]};
  end

  // ex2: form the four partial products.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
    end else if (en_i) begin
      pp_ll_q <= a_lo_x * b_lo_x;
      pp_lh_q <= a_lo_x * b_hi_x;
      pp_hl_q <= a_hi_x * b_lo_x;
      pp_hh_q <= a_hi_x * b_hi_x;
    end
  end

  // Weighted sum of the partial products, modulo 2^(2*DATA_WIDTH).
  always_comb begin
    ll_x = {{(PRW-PW){pp_ll_q[PW-1]}}, pp_ll_q};
    lh_x = {{(PRW-PW){pp_lh_q[PW-1]}}, pp_lh_q};
    hl_x = {{(PRW-PW){pp_hl_q[PW-1]}}, pp_hl_q};
    hh_x = {{(PRW-PW){pp_hh_q[PW-1]}}, pp_hh_q};
    product_d = ll_x + ((lh_x + hl_x) << HALF) + (hh_x << (2 * HALF));
  end

  // ex3: hold the full product; ex4: keep the half the op asks for.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      product_q <= '0;
      result_q  <= '0;
    end else if (en_i) begin
      product_q <= product_d;
      result_q  <= (ex3_op_i == MUL) ? product_q[DATA_WIDTH-1:0]
                                     : product_q[PRW-1:DATA_WIDTH];
    end
  end

  assign ex4_result_o = result_q;

endmodule

// File: rtl/ex_pipeline.sv
// Five-stage multiply execute pipeline. Owns the valid/tag shift register,
// the ex5 result register and the occupancy/writeback status outputs.
module ex_pipeline
  import params_pkg::*;
#(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int NUM_STAGES     = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  input  ex_op_t                    issue_op_i,
  input  logic [REGISTER_WIDTH-1:0] issue_wr_reg_i,
  input  logic [DATA_WIDTH-1:0]     issue_rs1_val_i,
  input  logic [DATA_WIDTH-1:0]     issue_rs2_val_i,
  input  logic                      stall_ex_i,
  output logic                      ex1_valid_o,
  output logic                      ex2_valid_o,
  output logic                      ex3_valid_o,
  output logic                      ex4_valid_o,
  output logic                      ex5_valid_o,
  output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
  output logic                      wb_is_next_cycle_o,
  output logic                      wb_valid_o,
  output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o
);

  // The stage struct is sized from the package, so overrides must agree.
  if (NUM_STAGES != 5) begin : g_bad_depth
    $error("ex_pipeline: NUM_STAGES must be 5");
  end
  if ((DATA_WIDTH != params_pkg::DATA_WIDTH) ||
      (REGISTER_WIDTH != params_pkg::REGISTER_WIDTH)) begin : g_bad_width
    $error("ex_pipeline: widths must match params_pkg");
  end

  ex_stage_t             stage_q [5];
  logic                  advance;
  logic [DATA_WIDTH-1:0] ex4_result;

  assign advance = !stall_ex_i;

  ex_mul_datapath #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_datapath (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (advance),
    .issue_op_i     (issue_op_i),
    .issue_rs1_val_i(issue_rs1_val_i),
    .issue_rs2_val_i(issue_rs2_val_i),
    .ex3_op_i       (stage_q[2].op),
    .ex4_result_o   (ex4_result)
  );

  // Shift valid/op/tag down the pipe; ex5 also captures the selected result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 5; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      stage_q[0] <= '{valid: issue_valid_i, op: issue_op_i,
                      wr_reg: issue_wr_reg_i, data: '0};
      for (int k = 1; k < 4; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
      stage_q[4] <= '{valid: stage_q[3].valid, op: stage_q[3].op,
                      wr_reg: stage_q[3].wr_reg, data: ex4_result};
    end
  end

  assign ex1_valid_o  = stage_q[0].valid;
  assign ex2_valid_o  = stage_q[1].valid;
  assign ex3_valid_o  = stage_q[2].valid;
  assign ex4_valid_o  = stage_q[3].valid;
  assign ex5_valid_o  = stage_q[4].valid;
  assign ex1_wr_reg_o = stage_q[0].wr_reg;
  assign ex2_wr_reg_o = stage_q[1].wr_reg;
  assign ex3_wr_reg_o = stage_q[2].wr_reg;
  assign ex4_wr_reg_o = stage_q[3].wr_reg;

  assign wb_is_next_cycle_o = stage_q[3].valid && advance;
  assign wb_valid_o         = stage_q[4].valid;
  assign wb_wr_reg_o        = stage_q[4].wr_reg;
  assign wb_data_o          = stage_q[4].valid ? stage_q[4].data : '0;

  // Decode must be frozen while execute is stalled; an issue here is lost.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(issue_valid_i && stall_ex_i));

endmodule

// File: tb/tb_ex_pipeline.sv
// Self-checking bench for ex_pipeline: directed cases with literal results
// plus randomized traffic against a slot-level reference model.
module tb_ex_pipeline;
  import params_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  ex_op_t      issue_op = MUL;
  logic [4:0]  issue_wr_reg = '0;
  logic [31:0] issue_rs1 = '0;
  logic [31:0] issue_rs2 = '0;
  logic        stall = 1'b0;
  logic        ex1_valid, ex2_valid, ex3_valid, ex4_valid, ex5_valid;
  logic [4:0]  ex1_wr_reg, ex2_wr_reg, ex3_wr_reg, ex4_wr_reg;
  logic        wb_is_next;
  logic        wb_valid;
  logic [4:0]  wb_wr_reg;
  logic [31:0] wb_data;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  ex_pipeline dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_op_i        (issue_op),
    .issue_wr_reg_i    (issue_wr_reg),
    .issue_rs1_val_i   (issue_rs1),
    .issue_rs2_val_i   (issue_rs2),
    .stall_ex_i        (stall),
    .ex1_valid_o       (ex1_valid),
    .ex2_valid_o       (ex2_valid),
    .ex3_valid_o       (ex3_valid),
    .ex4_valid_o       (ex4_valid),
    .ex5_valid_o       (ex5_valid),
    .ex1_wr_reg_o      (ex1_wr_reg),
    .ex2_wr_reg_o      (ex2_wr_reg),
    .ex3_wr_reg_o      (ex3_wr_reg),
    .ex4_wr_reg_o      (ex4_wr_reg),
    .wb_is_next_cycle_o(wb_is_next),
    .wb_valid_o        (wb_valid),
    .wb_wr_reg_o       (wb_wr_reg),
    .wb_data_o         (wb_data)
  );

  always #5 clk = ~clk;

  // Reference result straight from the arithmetic definition of each op.
  function automatic logic [31:0] refMul(ex_op_t op, logic [31:0] a, logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MUL:     p = ua * ub;
      MULH:    p = sa * sb;
      MULHU:   p = ua * ub;
      default: p = sa * ub;
    endcase
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  typedef struct {
    bit          valid;
    logic [4:0]  rd;
    logic [31:0] res;
  } slot_t;

  slot_t model [5];

  // Slot model: five occupancy slots that move together unless stalled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) model[i] = '{1'b0, 5'd0, 32'd0};
    end else if (!stall) begin
      for (int i = 4; i > 0; i--) model[i] = model[i-1];
      model[0] = '{issue_valid, issue_wr_reg,
                   refMul(issue_op, issue_rs1, issue_rs2)};
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Compare every DUT output against the slot model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("ex1_valid", {31'd0, ex1_valid}, {31'd0, model[0].valid});
      checkOutput("ex2_valid", {31'd0, ex2_valid}, {31'd0, model[1].valid});
      checkOutput("ex3_valid", {31'd0, ex3_valid}, {31'd0, model[2].valid});
      checkOutput("ex4_valid", {31'd0, ex4_valid}, {31'd0, model[3].valid});
      checkOutput("ex5_valid", {31'd0, ex5_valid}, {31'd0, model[4].valid});
      if (model[0].valid) checkOutput("ex1_wr_reg", {27'd0, ex1_wr_reg}, {27'd0, model[0].rd});
      if (model[1].valid) checkOutput("ex2_wr_reg", {27'd0, ex2_wr_reg}, {27'd0, model[1].rd});
      if (model[2].valid) checkOutput("ex3_wr_reg", {27'd0, ex3_wr_reg}, {27'd0, model[2].rd});
      if (model[3].valid) checkOutput("ex4_wr_reg", {27'd0, ex4_wr_reg}, {27'd0, model[3].rd});
      checkOutput("wb_is_next", {31'd0, wb_is_next}, {31'd0, model[3].valid && !stall});
      checkOutput("wb_valid", {31'd0, wb_valid}, {31'd0, model[4].valid});
      if (model[4].valid) checkOutput("wb_wr_reg", {27'd0, wb_wr_reg}, {27'd0, model[4].rd});
      checkOutput("wb_data", wb_data, model[4].valid ? model[4].res : 32'd0);
    end
  end

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic applyStimulus(bit v, bit s, ex_op_t op, logic [4:0] rd,
                               logic [31:0] a, logic [31:0] b);
    issue_valid  = v;
    stall        = s;
    issue_op     = op;
    issue_wr_reg = rd;
    issue_rs1    = a;
    issue_rs2    = b;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    stall       = 1'b0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] sign_expect [4];
  ex_op_t      sign_ops [4];
  bit          bubble_pat [5];

  initial begin
    sign_expect = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    sign_ops    = '{MUL, MULH, MULHU, MULHSU};
    bubble_pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    checking = 1'b1;

    $display("[TB] reset then idle");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
      checkOutput("idle_wb_next", {31'd0, wb_is_next}, 32'd0);
    end
    @(posedge clk);
    #1;

    $display("[TB] single MUL 7*6");
    applyStimulus(1'b1, 1'b0, MUL, 5'd5, 32'd7, 32'd6);
    @(negedge clk);
    checkOutput("single_ex1_valid", {31'd0, ex1_valid}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("single_wb_next", {31'd0, wb_is_next}, 32'd1);
    checkOutput("single_ex4_tag", {27'd0, ex4_wr_reg}, 32'd5);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("single_wb_reg", {27'd0, wb_wr_reg}, 32'd5);
    checkOutput("single_wb_data", wb_data, 32'd42);
    @(posedge clk);
    #1;

    $display("[TB] sign cases back-to-back");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, sign_ops[i], 5'(10 + i), 32'hFFFF_FFFF, 32'h0000_0002);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("sign_wb_valid", {31'd0, wb_valid}, 32'd1);
      checkOutput("sign_wb_reg", {27'd0, wb_wr_reg}, 32'(10 + i));
      checkOutput("sign_wb_data", wb_data, sign_expect[i]);
    end
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] stall in ex2");
    applyStimulus(1'b1, 1'b0, MUL, 5'd3, 32'd11, 32'd13);
    applyStimulus(1'b0, 1'b0, MUL, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      @(negedge clk);
      checkOutput("stall_ex2_valid", {31'd0, ex2_valid}, 32'd1);
      checkOutput("stall_ex3_valid", {31'd0, ex3_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_early_wb", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("stall_wb_reg", {27'd0, wb_wr_reg}, 32'd3);
    checkOutput("stall_wb_data", wb_data, 32'd143);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, MULHU, 5'(20 + i), $urandom, $urandom);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_ex1_valid", {31'd0, ex1_valid}, 32'd0);
    checkOutput("rst_ex3_valid", {31'd0, ex3_valid}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rst_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, MUL, 5'd9, 32'd100, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_wb_data", wb_data, 32'd300);
    @(posedge clk);
    #1;

    $display("[TB] bubble pattern");
    for (int i = 0; i < 5; i++)
      applyStimulus(bubble_pat[i], 1'b0, MULH, 5'(i + 1), $urandom, $urandom);
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        applyStimulus(1'b0, 1'b1, ex_op_t'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom);
      else
        applyStimulus(1'($urandom_range(0, 3) != 0), 1'b0, ex_op_t'($urandom_range(0, 3)),
                      5'($urandom), pickOperand(), pickOperand());
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
